// File: rtl/axi_ic_pkg.sv
// -----------------------------------------------------------------------------
// axi_ic_pkg
//   Shared types and helpers for the AXI interconnect write-path blocks.
//   - grant_width(): width of a binary master index (never less than 1).
//   - axi_len_t    : AXI awlen.
//   - route_entry_t: one outstanding write burst (winning master, its awlen).
// -----------------------------------------------------------------------------
package axi_ic_pkg;

    // Master index field is sized for the largest interconnect we build.
    // Instances narrow it to their own GrantWidth with a cast.
    localparam int MaxGrantWidth = 8;

    typedef logic [7:0] axi_len_t;

    typedef struct packed {
        logic [MaxGrantWidth-1:0] master;
        axi_len_t                 len;
    } route_entry_t;

    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered occupancy. The head word is read
//   combinationally from storage; a pushed word shows at the head no earlier
//   than the cycle after the push.
// Ports:
//   aclk, rst_n  clock, async active-low reset
//   push_i       write data_i at the tail (ignored when full)
//   data_i       tail write data
//   pop_i        advance the head (ignored when empty)
//   data_o       head word
//   full_o       count == Depth
//   empty_o      count == 0
//   count_o      occupancy
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter  int DataWidth = 8,
    parameter  int Depth     = 4,
    localparam int PtrWidth  = $clog2(Depth),
    localparam int CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 aclk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [CntWidth-1:0]  count_o
);

    logic [DataWidth-1:0] r_mem [Depth];
    logic [PtrWidth-1:0]  r_wr_ptr;
    logic [PtrWidth-1:0]  r_rd_ptr;
    logic [CntWidth-1:0]  r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    assign w_do_push = push_i & ~full_o;
    assign w_do_pop  = pop_i & ~empty_o;

    // Depth is a power of two, so the pointers wrap by plain overflow.
    // The separate count tells full from empty when the pointers are equal.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + PtrWidth'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CntWidth'(1);
                2'b01:   r_count <= r_count - CntWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign full_o  = (r_count == CntWidth'(Depth));
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

endmodule

// File: rtl/axi_ic_w_sched.sv
// -----------------------------------------------------------------------------
// axi_ic_w_sched
//   Per-slave W-channel route scheduler. Each accepted AW toward this slave
//   queues {winning master, awlen}; the head entry selects the W mux and is
//   retired on the WLAST beat. Counts beats of the head burst and pulses
//   wlast_err_o (registered) on an early or missing WLAST.
// Ports:
//   aclk, rst_n       clock, async active-low reset
//   aw_valid_i/ready_i AW handshake into this slave's skid buffer
//   aw_master_i       binary index of the AW winner
//   aw_len_i          awlen of that AW
//   aw_stall_o        route queue full; parent gates the AW handshake with it
//   w_route_valid_o   head entry present
//   w_master_o        master whose W beats go to this slave
//   wvalid_i/wready_i/wlast_i  W handshake on this slave's port
//   outstanding_o     queued bursts not yet closed by WLAST
//   wlast_err_o       one-cycle WLAST/awlen mismatch pulse
// -----------------------------------------------------------------------------
module axi_ic_w_sched
    import axi_ic_pkg::*;
#(
    parameter  int NumMasters     = 2,
    parameter  int MaxOutstanding = 4,
    localparam int GrantWidth     = grant_width(NumMasters),
    localparam int CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                  aclk,
    input  logic                  rst_n,
    input  logic                  aw_valid_i,
    input  logic                  aw_ready_i,
    input  logic [GrantWidth-1:0] aw_master_i,
    input  axi_len_t              aw_len_i,
    output logic                  aw_stall_o,
    output logic                  w_route_valid_o,
    output logic [GrantWidth-1:0] w_master_o,
    input  logic                  wvalid_i,
    input  logic                  wready_i,
    input  logic                  wlast_i,
    output logic [CntWidth-1:0]   outstanding_o,
    output logic                  wlast_err_o
);

    route_entry_t          w_push_entry;
    route_entry_t          w_head;
    logic                  w_full;
    logic                  w_empty;
    logic [CntWidth-1:0]   w_count;
    logic                  w_push;
    logic                  w_beat;
    logic                  w_pop;
    logic                  w_len_match;
    axi_len_t              r_beat_cnt;
    logic                  r_err;
    logic [GrantWidth-1:0] r_last_master;

    assign w_push_entry = '{master: MaxGrantWidth'(aw_master_i), len: aw_len_i};

    // Stall comes from the registered count, so a same-cycle pop while full
    // never makes room for a push in that cycle.
    assign w_push = aw_valid_i & aw_ready_i & ~w_full;
    assign w_beat = wvalid_i & wready_i & ~w_empty;
    assign w_pop  = w_beat & wlast_i;

    sync_fifo #(
        .DataWidth ($bits(route_entry_t)),
        .Depth     (MaxOutstanding)
    ) u_route_fifo (
        .aclk    (aclk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // Counter holds the index of the current beat within the head burst;
    // the last beat is due when it equals awlen.
    assign w_len_match = (r_beat_cnt == w_head.len);

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt    <= '0;
            r_err         <= 1'b0;
            r_last_master <= '0;
        end else begin
            if (w_pop)       r_beat_cnt <= '0;
            else if (w_beat) r_beat_cnt <= r_beat_cnt + 8'd1;   // wraps on a runaway burst
            // Early WLAST still pops; a missing WLAST keeps the route locked.
            r_err <= w_beat & (wlast_i ? ~w_len_match : w_len_match);
            if (!w_empty) r_last_master <= GrantWidth'(w_head.master);
        end
    end

    assign aw_stall_o      = w_full;
    assign w_route_valid_o = ~w_empty;
    assign w_master_o      = w_empty ? r_last_master : GrantWidth'(w_head.master);
    assign outstanding_o   = w_count;
    assign wlast_err_o     = r_err;

endmodule

// File: tb/tb_axi_ic_w_sched.sv
module tb_axi_ic_w_sched;

    localparam int NM = 2;
    localparam int MO = 4;

    logic       aclk = 1'b0;
    logic       rst_n;
    logic       aw_valid_i, aw_ready_i;
    logic [0:0] aw_master_i;
    logic [7:0] aw_len_i;
    logic       aw_stall_o, w_route_valid_o;
    logic [0:0] w_master_o;
    logic       wvalid_i, wready_i, wlast_i;
    logic [2:0] outstanding_o;
    logic       wlast_err_o;

    always #5 aclk = ~aclk;

    axi_ic_w_sched #(.NumMasters(NM), .MaxOutstanding(MO)) dut (
        .aclk            (aclk),
        .rst_n           (rst_n),
        .aw_valid_i      (aw_valid_i),
        .aw_ready_i      (aw_ready_i),
        .aw_master_i     (aw_master_i),
        .aw_len_i        (aw_len_i),
        .aw_stall_o      (aw_stall_o),
        .w_route_valid_o (w_route_valid_o),
        .w_master_o      (w_master_o),
        .wvalid_i        (wvalid_i),
        .wready_i        (wready_i),
        .wlast_i         (wlast_i),
        .outstanding_o   (outstanding_o),
        .wlast_err_o     (wlast_err_o)
    );

    // Reference model: ordered list of outstanding bursts, beats seen so far
    // in the head burst, and the error expected to be visible this cycle.
    typedef struct { int m; int len; } burst_t;
    burst_t q[$];
    int     m_beats;
    int     m_err;
    int     n_chk;
    int     n_fail;
    int     n_err_seen;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("aw_stall", int'(aw_stall_o), int'(q.size() == MO));
        chk("route_valid", int'(w_route_valid_o), int'(q.size() > 0));
        if (q.size() > 0) chk("w_master", int'(w_master_o), q[0].m);
        chk("outstanding", int'(outstanding_o), q.size());
        chk("wlast_err", int'(wlast_err_o), m_err);
        if (wlast_err_o === 1'b1) n_err_seen++;
    endtask

    task automatic clear_model();
        q.delete();
        m_beats = 0;
        m_err   = 0;
    endtask

    // One cycle: drive at negedge, check just after, advance model at posedge.
    task automatic step(input int p_aw, input int p_w, input int p_good_last);
        burst_t b;
        bit push, beat;
        int nerr;
        @(negedge aclk);
        aw_valid_i  = ($urandom_range(99) < p_aw);
        aw_ready_i  = ($urandom_range(99) < 80);
        aw_master_i = 1'($urandom_range(NM - 1));
        aw_len_i    = ($urandom_range(9) == 0) ? 8'($urandom_range(15)) : 8'($urandom_range(3));
        wvalid_i    = ($urandom_range(99) < p_w);
        wready_i    = ($urandom_range(99) < 80);
        if (q.size() > 0 && $urandom_range(99) < p_good_last)
            wlast_i = (m_beats == q[0].len);
        else
            wlast_i = 1'($urandom_range(1));
        #1;
        check_outputs();
        @(posedge aclk);
        push = aw_valid_i && aw_ready_i && (q.size() != MO);
        beat = wvalid_i && wready_i && (q.size() > 0);
        nerr = 0;
        if (beat) begin
            if (wlast_i) begin
                nerr = (m_beats != q[0].len);
                void'(q.pop_front());
                m_beats = 0;
            end else begin
                nerr = (m_beats == q[0].len);
                m_beats = (m_beats + 1) % 256;
            end
        end
        if (push) begin
            b.m   = int'(aw_master_i);
            b.len = int'(aw_len_i);
            q.push_back(b);
        end
        m_err = nerr;
    endtask

    task automatic zero_inputs();
        aw_valid_i = 0; aw_ready_i = 0; aw_master_i = 0; aw_len_i = 0;
        wvalid_i = 0; wready_i = 0; wlast_i = 0;
    endtask

    task automatic reset_check(input string tag);
        clear_model();
        chk({tag, "_master"}, int'(w_master_o), 0);
        check_outputs();
    endtask

    initial begin
        n_chk = 0; n_fail = 0; n_err_seen = 0;
        clear_model();
        zero_inputs();
        rst_n = 0;
        #23;
        reset_check("rst0");
        @(negedge aclk);
        rst_n = 1;

        // Fill to full with no W traffic, then keep pushing into a full queue.
        for (int i = 0; i < 12; i++) step(95, 0, 80);
        // Mixed traffic, mostly well-formed bursts.
        for (int i = 0; i < 600; i++) step(60, 60, 85);
        // Heavy AW pressure with draining: exercises pop+push while full.
        for (int i = 0; i < 400; i++) step(95, 40, 80);
        // Error-rich traffic: many early/missing WLASTs.
        for (int i = 0; i < 400; i++) step(50, 70, 40);

        // Reset mid-operation: build a backlog and a partial burst first.
        for (int i = 0; i < 40 && q.size() < 2; i++) step(95, 0, 80);
        for (int i = 0; i < 3; i++) step(0, 60, 0);
        @(negedge aclk);
        zero_inputs();
        rst_n = 0;
        #1;
        reset_check("rst_mid");
        @(negedge aclk);
        #1;
        check_outputs();
        rst_n = 1;

        // Fresh-FIFO behaviour after release, then more random traffic.
        for (int i = 0; i < 400; i++) step(60, 60, 75);

        // Drain and confirm the queue empties.
        for (int i = 0; i < 200 && q.size() > 0; i++) step(0, 100, 100);
        @(negedge aclk);
        zero_inputs();
        #1;
        check_outputs();
        chk("err_pulses_seen", int'(n_err_seen > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ic_w_sched.md
Name: axi_ic_w_sched

Overview:
- Per-slave write-data route scheduler for the AXI interconnect, one instance per slave port.
- Records which master won each AW handshake toward this slave, in order, together with that burst's awlen.
- Presents the head entry as the W-channel mux select for that slave, and retires it on the WLAST beat.
- Limits outstanding write bursts and flags W beat-count/WLAST mismatches against awlen.

Parameters:
- NumMasters, 2, number of masters sharing this slave port.
- MaxOutstanding, 4, depth of the route FIFO (outstanding AW bursts without WLAST); power of two, >=2.
- GrantWidth (localparam), $clog2(NumMasters), or 1 if that is 0; width of the master index.
- CntWidth (localparam), $clog2(MaxOutstanding+1); width of the occupancy count.

Ports:
- aclk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- aw_valid_i  input  1  arbitrated AW valid into this slave's AW skid buffer.
- aw_ready_i  input  1  ready from this slave's AW skid buffer.
- aw_master_i  input  GrantWidth  binary grant of the current AW arbitration winner.
- aw_len_i  input  8  awlen of the granted AW.
- aw_stall_o  output  1  route FIFO full; the parent gates aw_valid/aw_ready toward the skid buffer with it.
- w_route_valid_o  output  1  head entry present; W mux select is meaningful.
- w_master_o  output  GrantWidth  master whose W beats are routed to this slave.
- wvalid_i  input  1  wvalid on this slave's W output.
- wready_i  input  1  wready from the slave.
- wlast_i  input  1  wlast on this slave's W output.
- outstanding_o  output  CntWidth  FIFO occupancy.
- wlast_err_o  output  1  one-cycle pulse on a WLAST/awlen mismatch.

Behaviour:
- Reset (async assert, sync release): FIFO empty, beat counter 0; aw_stall_o=0, w_route_valid_o=0, w_master_o=0, outstanding_o=0, wlast_err_o=0.
- Push:
  - Condition: aw_valid_i & aw_ready_i & ~aw_stall_o.
  - Writes {aw_master_i, aw_len_i} at the tail.
  - Entry is visible at the head the next cycle at the earliest; there is no same-cycle bypass.
- W beat:
  - Condition: wvalid_i & wready_i & w_route_valid_o.
  - Beats arriving while w_route_valid_o=0 are ignored; the parent must hold W wready low while the FIFO is empty.
- Pop: on a W beat with wlast_i=1; the head advances and the beat counter clears to 0.
- Beat counter: 8 bits, increments on each non-last W beat, compared against head len.
- wlast_err_o fires the cycle after either mismatch (registered):
  - wlast_i=1 with counter != head len (early WLAST); the entry is still popped.
  - wlast_i=0 with counter == head len (missing WLAST); no pop, counter wraps naturally, and the route stays locked until WLAST.
- aw_stall_o = (occupancy == MaxOutstanding), registered-equivalent (derived from the occupancy register).
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - Allowed when full: the pop frees a slot, but aw_stall_o is still 1 in that cycle, so no push occurs.
  - Allowed when 1 entry: the head pops and the new tail becomes head next cycle.
- Pointers wrap modulo MaxOutstanding; occupancy is tracked separately to disambiguate full from empty.
- Reset mid-burst discards all entries and the counter; no error pulse is generated.
- w_master_o holds the head value while valid and holds its last value while empty (don't-care to consumers).

Decomposition:
- Package axi_ic_pkg:
  - grant_width(n) function.
  - typedef axi_len_t (logic [7:0]).
  - route entry struct {master idx, len}.
- Sub-module sync_fifo (DataWidth, Depth; aclk/rst_n; push/pop/full/empty/count) holds the route entries.
- The scheduler adds push/pop qualification, the beat counter and error detection.

Test Plan:
- Single burst: push master 1 with len 3, then 4 W beats with wlast on the 4th -> w_master_o=1, w_route_valid_o=1 from the cycle after push, pop on the 4th beat, outstanding_o 1->0, no error.
- Order preservation: push masters 0,1,0 back-to-back, each len 0 -> w_master_o sequence 0,1,0, one per wlast beat.
- Full: 4 pushes with no W -> outstanding_o=4, aw_stall_o=1; a 5th aw_valid_i&aw_ready_i is not stored. Then pop + push attempt in the same cycle -> occupancy 3, no push; next cycle aw_stall_o=0.
- Early WLAST: len 3, wlast on the 2nd beat -> wlast_err_o=1 for one cycle, entry popped.
- Missing WLAST: len 1, 2nd beat without wlast -> wlast_err_o pulse, no pop; a later wlast beat pops.
- Reset mid-operation: rst_n low with 2 entries and a partial burst -> all outputs return to reset values immediately; after release, the first push behaves as on a fresh FIFO.
